e_mdu: RTL and testbench

- Multiply/divide unit with its own sequencer, placed in the E stage beside the ALU.
- Accepts mult/multu/div/divu, holds the operation for a fixed number of cycles, then commits the result to the HI/LO registers.
- Serves mfhi/mflo/mthi/mtlo.
- Drives busy to the hazard unit, which stalls any later MDU instruction in D while the unit is occupied.
- An exception/interrupt request suppresses starting a new operation and suppresses HI/LO writes from the instruction in E.

---
 rtl/e_mdu_pkg.sv | 24 ++
 rtl/e_mdu.sv | 123 ++++++++++++
 tb/tb_e_mdu.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared encodings for the E-stage multiply/divide unit: MDU opcodes and sequencer states.
package e_mdu_pkg;

    localparam logic [3:0] MDUop_none  = 4'd0;
    localparam logic [3:0] MDUop_mult  = 4'd1;
    localparam logic [3:0] MDUop_multu = 4'd2;
    localparam logic [3:0] MDUop_div   = 4'd3;
    localparam logic [3:0] MDUop_divu  = 4'd4;
    localparam logic [3:0] MDUop_mfhi  = 4'd5;
    localparam logic [3:0] MDUop_mflo  = 4'd6;
    localparam logic [3:0] MDUop_mthi  = 4'd7;
    localparam logic [3:0] MDUop_mtlo  = 4'd8;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mduState_t;

    function automatic logic isLongOp(input logic [3:0] op);
        return (op == MDUop_mult) || (op == MDUop_multu) ||
               (op == MDUop_div)  || (op == MDUop_divu);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: latches the result at start, holds busy for a fixed
// cycle count, then commits to HI/LO. Also serves mfhi/mflo/mthi/mtlo.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        start,
    input  logic [3:0]  MDUop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] MDUout,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    mduState_t   state, stateNext;
    logic [31:0] counter;
    logic [31:0] pendHI, pendLO;
    logic [31:0] pendHiNext, pendLoNext;
    logic        accept, commit, moveOk;

    logic [63:0] aExt, bExt, prodS, prodU;
    assign aExt  = {{32{A[31]}}, A};
    assign bExt  = {{32{B[31]}}, B};
    assign prodS = aExt * bExt;
    assign prodU = {32'd0, A} * {32'd0, B};

    // Writes from the E-stage instruction only count when no flush is pending.
    assign moveOk = start && !req && (state == MDU_IDLE);
    assign accept = moveOk && isLongOp(MDUop);
    assign commit = (state == MDU_RUN) && (counter == 32'd1);
    assign busy   = (state == MDU_RUN);

    always_comb begin
        stateNext = state;
        case (state)
            MDU_IDLE: if (accept) stateNext = MDU_RUN;
            MDU_RUN:  if (commit) stateNext = MDU_IDLE;
            default:  stateNext = MDU_IDLE;
        endcase
    end

    // Divide by zero keeps HI/LO; the most-negative / -1 case is pinned so it
    // does not depend on how the simulator wraps the overflowing quotient.
    always_comb begin
        pendHiNext = HI;
        pendLoNext = LO;
        case (MDUop)
            MDUop_mult: begin
                pendHiNext = prodS[63:32];
                pendLoNext = prodS[31:0];
            end
            MDUop_multu: begin
                pendHiNext = prodU[63:32];
                pendLoNext = prodU[31:0];
            end
            MDUop_div: begin
                if (B == 32'd0) begin
                    pendHiNext = HI;
                    pendLoNext = LO;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    pendHiNext = 32'd0;
                    pendLoNext = 32'h8000_0000;
                end else begin
                    pendHiNext = $signed(A) % $signed(B);
                    pendLoNext = $signed(A) / $signed(B);
                end
            end
            MDUop_divu: begin
                if (B != 32'd0) begin
                    pendHiNext = A % B;
                    pendLoNext = A / B;
                end
            end
            default: begin
                pendHiNext = HI;
                pendLoNext = LO;
            end
        endcase
    end

    always_comb begin
        MDUout = 32'd0;
        if (MDUop == MDUop_mfhi) MDUout = HI;
        else if (MDUop == MDUop_mflo) MDUout = LO;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= MDU_IDLE;
            counter <= 32'd0;
            pendHI  <= 32'd0;
            pendLO  <= 32'd0;
            HI      <= 32'd0;
            LO      <= 32'd0;
        end else begin
            state <= stateNext;
            if (accept) begin
                pendHI  <= pendHiNext;
                pendLO  <= pendLoNext;
                counter <= (MDUop == MDUop_div || MDUop == MDUop_divu) ?
                           32'(DIV_CYCLES) : 32'(MULT_CYCLES);
            end else if (state == MDU_RUN) begin
                counter <= counter - 32'd1;
            end
            if (commit) begin
                HI <= pendHI;
                LO <= pendLO;
            end else if (moveOk && MDUop == MDUop_mthi) begin
                HI <= A;
            end else if (moveOk && MDUop == MDUop_mtlo) begin
                LO <= A;
            end
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: arithmetic results, busy duration, moves, flush and reset cases.
module tb_e_mdu;
    import e_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req, start;
    logic [3:0]  MDUop;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] MDUout, HI, LO;

    int errors = 0;
    int checks = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .MDUop(MDUop),
        .A(A), .B(B), .busy(busy), .MDUout(MDUout), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts busy samples from now until idle, bounded.
    task automatic countBusy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cycle();
        end
    endtask

    task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int expN,
                         input logic [31:0] expHi, input logic [31:0] expLo);
        int n;
        req = 1'b0; start = 1'b1; MDUop = op; A = a; B = b;
        cycle();
        start = 1'b0; MDUop = MDUop_none;
        countBusy(n);
        chk({tag, "_busy_len"}, 32'(n), 32'(expN));
        chk({tag, "_hi"}, HI, expHi);
        chk({tag, "_lo"}, LO, expLo);
    endtask

    initial begin
        int n;
        reset = 1'b1; req = 1'b0; start = 1'b0; MDUop = MDUop_none; A = '0; B = '0;
        cycle(); cycle();
        reset = 1'b0;
        cycle();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_mduout", MDUout, 32'd0);

        runOp("mult", MDUop_mult, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        runOp("multu", MDUop_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        runOp("div", MDUop_div, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("div0", MDUop_div, 32'd55, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        runOp("divu", MDUop_divu, 32'd100, 32'd7, 10, 32'd2, 32'd14);
        runOp("divovf", MDUop_div, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);

        // Moves and reads
        start = 1'b1; MDUop = MDUop_mthi; A = 32'h1234_5678;
        cycle();
        start = 1'b0;
        chk("mthi_hi", HI, 32'h1234_5678);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        MDUop = MDUop_mflo; #1;
        chk("mflo_out", MDUout, 32'h8000_0000);
        start = 1'b1; MDUop = MDUop_mtlo; A = 32'hCAFE_F00D;
        cycle();
        start = 1'b0;
        chk("mtlo_lo", LO, 32'hCAFE_F00D);
        MDUop = MDUop_mfhi; #1;
        chk("mfhi_out", MDUout, 32'h1234_5678);
        MDUop = MDUop_mflo; #1;
        chk("mflo_out2", MDUout, 32'hCAFE_F00D);
        MDUop = MDUop_mult; #1;
        chk("mduout_other", MDUout, 32'd0);

        // Flush blocks a start and a move
        req = 1'b1; start = 1'b1; MDUop = MDUop_mult; A = 32'd5; B = 32'd5;
        cycle();
        chk("req_busy", {31'd0, busy}, 32'd0);
        MDUop = MDUop_mthi; A = 32'hDEAD_BEEF;
        cycle();
        start = 1'b0; req = 1'b0; MDUop = MDUop_none;
        chk("req_busy2", {31'd0, busy}, 32'd0);
        chk("req_hi", HI, 32'h1234_5678);
        chk("req_lo", LO, 32'hCAFE_F00D);

        // Flush raised mid-run does not cancel the older operation
        start = 1'b1; MDUop = MDUop_mult; A = 32'd6; B = 32'd7;
        cycle();
        start = 1'b0; req = 1'b1; MDUop = MDUop_none;
        countBusy(n);
        req = 1'b0;
        chk("reqmid_busy_len", 32'(n), 32'd5);
        chk("reqmid_hi", HI, 32'd0);
        chk("reqmid_lo", LO, 32'd42);

        // Starts and moves while running are ignored
        start = 1'b1; MDUop = MDUop_mult; A = 32'd2; B = 32'd3;
        cycle();
        MDUop = MDUop_mthi; A = 32'hDEAD_BEEF;
        cycle();
        MDUop = MDUop_div; A = 32'd100; B = 32'd3;
        cycle();
        start = 1'b0; MDUop = MDUop_none;
        countBusy(n);
        chk("ignore_busy_len", 32'(n + 2), 32'd5);
        chk("ignore_hi", HI, 32'd0);
        chk("ignore_lo", LO, 32'd6);

        // Back-to-back: second start lands in the first idle cycle
        runOp("b2b_a", MDUop_multu, 32'd3, 32'd4, 5, 32'd0, 32'd12);
        runOp("b2b_b", MDUop_mult, 32'hFFFF_FFFF, 32'd5, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // Reset during a divide aborts it with no late commit
        start = 1'b1; MDUop = MDUop_div; A = 32'd20; B = 32'd3;
        cycle();
        start = 1'b0; MDUop = MDUop_none;
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", HI, 32'd0);
        chk("rstmid_lo", LO, 32'd0);
        repeat (12) cycle();
        chk("rstmid_late_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_late_hi", HI, 32'd0);
        chk("rstmid_late_lo", LO, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
